// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding, default operand width and counter sizing.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; always at least one bit.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mult_add_step.sv
// WIDTH-bit ripple-carry adder with carry-out: the single partial-product
// add performed per BUSY cycle of the multiplier.
module mult_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mult_fa u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/mult_fa.sv
// One-bit full adder cell, the building block of the ripple-carry chain.
module mult_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier. One partial-product add per clock,
// WIDTH iterations, valid/ready handshakes on both operand and result sides.
// Optional feature: define MULT_SIGNED_EN for two's-complement operands
// (magnitudes multiplied, product negated on entry to DONE).
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               overflow
);

    localparam int              CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nx;
    logic [2*WIDTH-1:0]   prod_nx;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     ld_a;
    logic [WIDTH-1:0]     ld_b;
    logic [CW-1:0]        count;
    logic                 carry;
    logic                 ovf_nx;
    logic                 accept;
    logic                 fire;
    logic                 last;

    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign accept       = start_valid & start_ready;
    assign fire         = result_valid & result_ready;
    assign last         = (state == BUSY) && (count == LAST);

    // Add the multiplicand into the high half only when the current
    // multiplier bit (acc LSB) is set; the carry is kept for the shift.
    assign addend = acc[0] ? mcand : '0;

    mult_add_step #(.WIDTH(WIDTH)) u_add (
        .x    (acc[2*WIDTH-1:WIDTH]),
        .y    (addend),
        .sum  (sum),
        .cout (carry)
    );

    assign acc_nx = {carry, sum, acc[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    logic sign;

    // Magnitudes; the most-negative value maps to 2^(W-1), still fits.
    assign ld_a    = a[WIDTH-1] ? (~a + ONE_W) : a;
    assign ld_b    = b[WIDTH-1] ? (~b + ONE_W) : b;
    assign prod_nx = sign ? (~acc_nx + ONE_2W) : acc_nx;
    assign ovf_nx  = (prod_nx[2*WIDTH-1:WIDTH] != {WIDTH{prod_nx[WIDTH-1]}});

    // Result sign captured at operand acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign <= 1'b0;
        end else if (accept) begin
            sign <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign ld_a    = a;
    assign ld_b    = b;
    assign prod_nx = acc_nx;
    assign ovf_nx  = |acc_nx[2*WIDTH-1:WIDTH];
`endif

    // Control FSM: IDLE -> BUSY on accept, BUSY -> DONE after WIDTH
    // iterations, DONE -> IDLE on result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= BUSY;
                BUSY:    if (last)   state <= DONE;
                DONE:    if (fire)   state <= IDLE;
                default:             state <= IDLE;
            endcase
        end
    end

    // Shift register, multiplicand and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= {{WIDTH{1'b0}}, ld_b};
            mcand <= ld_a;
            count <= '0;
        end else if (state == BUSY) begin
            acc   <= acc_nx;
            count <= count + 1'b1;
        end
    end

    // Product and overflow are captured on the final iteration and held
    // stable through DONE until the next operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product  <= '0;
            overflow <= 1'b0;
        end else if (last) begin
            product  <= prod_nx;
            overflow <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH = 32). Stimulus pushes expected
// {product, overflow}; a negedge monitor compares whenever result_valid is up.
module tb_seq_multiplier;

    localparam int W = 32;

    typedef struct packed {
        logic [2*W-1:0] p;
        logic           o;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           result_valid;
    logic           result_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           overflow;

    exp_t sb[$];
    exp_t popped;
    int   total = 0;
    int   bad   = 0;
    int   k;
    int   t;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product),
        .overflow     (overflow)
    );

    task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_start_ready"},  start_ready,  1);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_product"},      product,      0);
        chk({tag, "_overflow"},     overflow,     0);
    endtask

    // Wait for IDLE (bounded), present operands for one accept edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] p, input logic o);
        int n = 0;
        while (!start_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("issue_ready", start_ready, 1);
        start_valid = 1'b1;
        a = x;
        b = y;
        sb.push_back('{p: p, o: o});
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = '0;
        b = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_timeout_qsize", sb.size(), 0);
    endtask

    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2*W-1:0] p, input logic o);
        result_ready = 1'b1;
        issue(x, y, p, o);
        wait_drain();
    endtask

    // Monitor: whenever a result is presented, compare against the oldest
    // expectation; pop it only when the handshake completes.
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result_qsize", sb.size(), 1);
            end else begin
                chk("product",     product,     sb[0].p);
                chk("overflow",    overflow,    sb[0].o);
                chk("done_sready", start_ready, 0);
                if (result_ready) popped = sb.pop_front();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset held for 3 cycles.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3 x 5 with latency measurement, ignored starts during BUSY/DONE,
        // and 10 cycles of result backpressure.
        result_ready = 1'b0;
        issue(3, 5, 15, 0);
        k = 0;
        while (!result_valid && k < 60) begin
            chk("busy_sready", start_ready, 0);
            start_valid = (k % 5 == 4);
            a = 9;
            b = 9;
            @(posedge clk); #1;
            k++;
        end
        start_valid = 1'b0;
        chk("latency_cycles", k + 1, W + 1);
        repeat (10) begin
            start_valid = 1'b1;
            a = 9;
            b = 9;
            @(posedge clk); #1;
            chk("bp_result_valid", result_valid, 1);
            chk("bp_start_ready",  start_ready,  0);
        end
        start_valid = 1'b0;
        result_ready = 1'b1;
        wait_drain();
        run(9, 9, 81, 0);

        // Reset on BUSY cycle 10 of 0x1234 x 0x5678.
        result_ready = 1'b1;
        issue(32'h1234, 32'h5678, 64'h0000_0000_0626_0060, 0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_busy");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(7, 6, 42, 0);

`ifndef MULT_SIGNED_EN
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1);
        run(32'h0000_0000, 32'hFFFF_FFFF, 64'h0, 0);
        run(32'h0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 0);
        run(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1);
        run(32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 1);
`else
        run(32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 0);
        run(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1);
        run(32'hFFFF_FFFC, 32'h0000_0000, 64'h0, 0);
        run(32'hFFFF_FFF9, 32'hFFFF_FFFA, 64'h0000_0000_0000_002A, 0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0);
`endif

        // Reset asserted while a result is held in DONE.
        result_ready = 1'b0;
        issue(100, 200, 20000, 0);
        t = 0;
        while (!result_valid && t < 60) begin
            @(posedge clk); #1; t++;
        end
        chk("reach_done", result_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_done");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(11, 13, 143, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
